// File: rtl/sgbm_clk_monitor.sv
// Lock monitor for the divided SGBM clock: measures its period on clkin, locks
// after a run of good periods and drives a synchronously released downstream reset.
module sgbm_clk_monitor #(
  parameter int EXP_PERIOD = 4,
  parameter int TOL        = 0,
  parameter int LOCK_CNT   = 16,
  parameter int TIMEOUT    = 64,
  parameter int CW         = 8
) (
  input  logic          clkin,
  input  logic          restn,
  input  logic          clk_sample,
  output logic          locked,
  output logic          rst_out_n,
  output logic          err_pulse,
  output logic [CW-1:0] period_meas
);

  localparam int GW = (LOCK_CNT > 1) ? $clog2(LOCK_CNT + 1) : 1;
  localparam logic [CW-1:0] TMO     = CW'(TIMEOUT);
  localparam logic [GW-1:0] LOCK_GW = GW'(LOCK_CNT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    LOCKED = 2'd2
  } state_e;

  state_e        state_q;
  logic          s1_q, s2_q, s3_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [CW-1:0] period_q;
  logic [GW-1:0] good_q;
  logic [GW-1:0] good_d;
  logic          locked_q;
  logic          rst_q;
  logic          err_q;
  logic          edge_det;
  logic          good_per;
  logic          timeout;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + 1'b1;
  endfunction

  function automatic logic in_tol(input logic [CW-1:0] c);
    int d;
    d = int'(c) - EXP_PERIOD;
    if (d < 0) d = -d;
    return (d <= TOL);
  endfunction

  // s2/s3 are past the metastability window, so the edge pulse has a fixed latency
  assign edge_det = s2_q & ~s3_q;
  assign good_per = in_tol(cnt_q);
  assign timeout  = (cnt_q == TMO) && !edge_det;
  assign cnt_d    = sat_inc(cnt_q);
  assign good_d   = good_q + 1'b1;

  always_ff @(posedge clkin or negedge restn) begin
    if (!restn) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      cnt_q    <= '0;
      period_q <= '0;
      good_q   <= '0;
      locked_q <= 1'b0;
      rst_q    <= 1'b0;
      err_q    <= 1'b0;
      state_q  <= IDLE;
    end else begin
      s1_q  <= clk_sample;
      s2_q  <= s1_q;
      s3_q  <= s2_q;
      err_q <= 1'b0;
      rst_q <= locked_q;
      cnt_q <= cnt_d;
      case (state_q)
        IDLE: begin
          if (edge_det) begin
            cnt_q   <= CW'(1);
            state_q <= SEARCH;
          end
        end
        SEARCH: begin
          if (edge_det) begin
            cnt_q    <= CW'(1);
            period_q <= cnt_q;
            if (good_per) begin
              if (good_d == LOCK_GW) begin
                good_q   <= '0;
                locked_q <= 1'b1;
                state_q  <= LOCKED;
              end else begin
                good_q <= good_d;
              end
            end else begin
              good_q <= '0;
              err_q  <= 1'b1;
            end
          end else if (timeout) begin
            cnt_q   <= '0;
            good_q  <= '0;
            err_q   <= 1'b1;
            state_q <= IDLE;
          end
        end
        LOCKED: begin
          if (edge_det) begin
            cnt_q    <= CW'(1);
            period_q <= cnt_q;
            if (!good_per) begin
              good_q   <= '0;
              locked_q <= 1'b0;
              err_q    <= 1'b1;
              state_q  <= SEARCH;
            end
          end else if (timeout) begin
            cnt_q    <= '0;
            good_q   <= '0;
            locked_q <= 1'b0;
            err_q    <= 1'b1;
            state_q  <= IDLE;
          end
        end
        default: begin
          locked_q <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign locked      = locked_q;
  assign rst_out_n   = rst_q;
  assign err_pulse   = err_q;
  assign period_meas = period_q;

endmodule

// File: tb/tb_sgbm_clk_monitor.sv
// Directed bench for sgbm_clk_monitor: default, tolerant (TOL=1) and narrow
// (CW=4, TIMEOUT=15) instances share clock and reset, each with its own sample clock.
module tb_sgbm_clk_monitor;

  logic       clkin;
  logic       restn;
  logic       cs0, cs1, cs2;
  logic       lk0, lk1, lk2;
  logic       ro0, ro1, ro2;
  logic       er0, er1, er2;
  logic [7:0] pm0, pm1;
  logic [3:0] pm2;
  int         e0, e1, e2;
  int         snap;
  int         checks;
  int         errors;

  sgbm_clk_monitor u0 (
    .clkin(clkin), .restn(restn), .clk_sample(cs0), .locked(lk0),
    .rst_out_n(ro0), .err_pulse(er0), .period_meas(pm0)
  );

  sgbm_clk_monitor #(.TOL(1)) u1 (
    .clkin(clkin), .restn(restn), .clk_sample(cs1), .locked(lk1),
    .rst_out_n(ro1), .err_pulse(er1), .period_meas(pm1)
  );

  sgbm_clk_monitor #(.CW(4), .TIMEOUT(15)) u2 (
    .clkin(clkin), .restn(restn), .clk_sample(cs2), .locked(lk2),
    .rst_out_n(ro2), .err_pulse(er2), .period_meas(pm2)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  always @(posedge clkin) begin
    if (er0) e0 <= e0 + 1;
    if (er1) e1 <= e1 + 1;
    if (er2) e2 <= e2 + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clkin);
      #1;
    end
  endtask

  task automatic set_cs(input int sel, input logic v);
    case (sel)
      0: cs0 = v;
      1: cs1 = v;
      default: cs2 = v;
    endcase
  endtask

  task automatic period(input int sel, input int hi, input int lo);
    set_cs(sel, 1'b1);
    cyc(hi);
    set_cs(sel, 1'b0);
    cyc(lo);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    e0 = 0; e1 = 0; e2 = 0;
    restn = 1'b0;
    cs0 = 1'b0; cs1 = 1'b0; cs2 = 1'b0;
    cyc(3);
    chk("rst_locked", {29'd0, lk0, lk1, lk2}, 32'd0);
    chk("rst_rstout", {29'd0, ro0, ro1, ro2}, 32'd0);
    chk("rst_err", {29'd0, er0, er1, er2}, 32'd0);
    chk("rst_pm0", 32'(pm0), 32'd0);
    chk("rst_pm2", 32'(pm2), 32'd0);
    restn = 1'b1;

    // nominal lock: 16 periods, 17th edge locks
    snap = e0;
    repeat (16) period(0, 2, 2);
    chk("nom_not_locked", 32'(lk0), 32'd0);
    set_cs(0, 1'b1); cyc(2);
    chk("nom_pre_lock", 32'(lk0), 32'd0);
    set_cs(0, 1'b0); cyc(1);
    chk("nom_locked", 32'(lk0), 32'd1);
    chk("nom_rstout_lag", 32'(ro0), 32'd0);
    chk("nom_pm", 32'(pm0), 32'd4);
    cyc(1);
    chk("nom_rstout", 32'(ro0), 32'd1);
    chk("nom_no_err", 32'(e0 - snap), 32'd0);

    // bad period of 5 while locked
    period(0, 3, 2);
    set_cs(0, 1'b1); cyc(2);
    set_cs(0, 1'b0); cyc(1);
    chk("bad_err", 32'(er0), 32'd1);
    chk("bad_unlock", 32'(lk0), 32'd0);
    chk("bad_pm", 32'(pm0), 32'd5);
    chk("bad_rstout_lag", 32'(ro0), 32'd1);
    cyc(1);
    chk("bad_err_width", 32'(er0), 32'd0);
    chk("bad_rstout", 32'(ro0), 32'd0);
    snap = e0;
    repeat (15) period(0, 2, 2);
    set_cs(0, 1'b1); cyc(2);
    chk("relock_pre", 32'(lk0), 32'd0);
    set_cs(0, 1'b0); cyc(1);
    chk("relock", 32'(lk0), 32'd1);
    chk("relock_pm", 32'(pm0), 32'd4);
    chk("relock_no_err", 32'(e0 - snap), 32'd0);

    // stall: timeout fires when cnt reaches 64
    cyc(63);
    chk("stall_pre_err", 32'(er0), 32'd0);
    chk("stall_pre_lock", 32'(lk0), 32'd1);
    cyc(1);
    chk("stall_err", 32'(er0), 32'd1);
    chk("stall_unlock", 32'(lk0), 32'd0);
    cyc(1);
    chk("stall_err_width", 32'(er0), 32'd0);
    chk("stall_rstout", 32'(ro0), 32'd0);
    chk("stall_pm_held", 32'(pm0), 32'd4);
    snap = e0;
    repeat (16) period(0, 2, 2);
    set_cs(0, 1'b1); cyc(2);
    chk("resume_pre", 32'(lk0), 32'd0);
    set_cs(0, 1'b0); cyc(1);
    chk("resume_lock", 32'(lk0), 32'd1);
    chk("resume_no_err", 32'(e0 - snap), 32'd0);
    cyc(1);
    chk("resume_rstout", 32'(ro0), 32'd1);

    // asynchronous reset mid-lock
    #2;
    restn = 1'b0;
    #1;
    chk("arst_locked", 32'(lk0), 32'd0);
    chk("arst_rstout", 32'(ro0), 32'd0);
    chk("arst_pm", 32'(pm0), 32'd0);
    chk("arst_err", 32'(er0), 32'd0);
    @(posedge clkin);
    #1;
    restn = 1'b1;
    snap = e0;
    repeat (16) period(0, 2, 2);
    set_cs(0, 1'b1); cyc(2);
    chk("rearm_pre", 32'(lk0), 32'd0);
    set_cs(0, 1'b0); cyc(1);
    chk("rearm_lock", 32'(lk0), 32'd1);
    chk("rearm_no_err", 32'(e0 - snap), 32'd0);

    // tolerance: alternating periods 3 and 5 with TOL=1
    snap = e1;
    repeat (8) begin
      period(1, 1, 2);
      period(1, 2, 3);
    end
    set_cs(1, 1'b1); cyc(1);
    set_cs(1, 1'b0); cyc(1);
    chk("tol_pre", 32'(lk1), 32'd0);
    cyc(1);
    chk("tol_lock", 32'(lk1), 32'd1);
    chk("tol_pm", 32'(pm1), 32'd5);
    chk("tol_no_err", 32'(e1 - snap), 32'd0);
    cyc(3);
    set_cs(1, 1'b1); cyc(1);
    set_cs(1, 1'b0); cyc(2);
    chk("tol6_err", 32'(er1), 32'd1);
    chk("tol6_pm", 32'(pm1), 32'd6);
    chk("tol6_unlock", 32'(lk1), 32'd0);

    // narrow counter: edge at cnt==TIMEOUT wins, then slow clock times out each period
    set_cs(2, 1'b1); cyc(2);
    set_cs(2, 1'b0); cyc(1);
    chk("sat_first_pm", 32'(pm2), 32'd0);
    snap = e2;
    cyc(12);
    set_cs(2, 1'b1); cyc(2);
    set_cs(2, 1'b0); cyc(1);
    chk("sat_edge_wins_err", 32'(er2), 32'd1);
    chk("sat_edge_wins_pm", 32'(pm2), 32'd15);
    cyc(1);
    chk("sat_single_err", 32'(e2 - snap), 32'd1);
    snap = e2;
    cyc(16);
    repeat (3) period(2, 2, 18);
    chk("sat_err_every_period", 32'(e2 - snap), 32'd4);
    chk("sat_pm_cap", 32'(pm2), 32'd15);
    chk("sat_unlocked", 32'(lk2), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
